// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, debug and memory-side signals of the data-memory arbiter.
// Latency: wires only; memory read data returns one cycle after a granted read.
// Backpressure: requesters hold req/we/addr/wdata stable until they see their gnt.
// Ports (slave = arbiter view):
//   core_*  : core load/store request in; gnt, stall, rvalid, rdata out
//   dbg_*   : debug/loader request and lock in; gnt, rvalid, rdata out
//   mem_*   : single-port memory enable/we/addr/wdata out; mem_rdata in
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core and a debug/loader port.
// Latency: grants are combinational; read data valid (rvalid) one cycle after a granted read.
// Backpressure: a denied requester sees gnt=0 (core also sees core_stall) and holds its request.
// Ports: clk, n_rst (async, active-low), bus (dmem_arbiter_if.slave: core_*, dbg_*, mem_*).
// Option: define DMEM_ARB_RR_EN for strict round-robin between core and debug instead of
//         core-first priority with a debug starvation counter; the lock behaviour is the same.
module dmem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4
) (
  input logic           clk,
  input logic           n_rst,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    CORE_PRI = 2'd0,
    DBG_PRI  = 2'd1,
    LOCK     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          core_gnt, dbg_gnt;
  logic          core_rvalid, dbg_rvalid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    core_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    starve_nxt = '0;
    state_nxt  = state;

    case (state)
      CORE_PRI: begin
        core_gnt = bus.core_req;
        dbg_gnt  = bus.dbg_req & ~bus.core_req;
      end
      DBG_PRI: begin
        dbg_gnt  = bus.dbg_req;
        core_gnt = bus.core_req & ~bus.dbg_req;
      end
      // Memory belongs to debug for the whole burst, even in its idle cycles.
      LOCK:    dbg_gnt = bus.dbg_req;
      default: ;
    endcase

    // No access may leave the arbiter while reset is held.
    if (!n_rst) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
    end

`ifdef DMEM_ARB_RR_EN
    // Strict alternation: whoever was just served hands priority to the other port.
    case (state)
      CORE_PRI: if (core_gnt) state_nxt = DBG_PRI;
      DBG_PRI:  if (dbg_gnt)  state_nxt = CORE_PRI;
      LOCK:     if (!bus.dbg_lock) state_nxt = CORE_PRI;
      default:  state_nxt = CORE_PRI;
    endcase
`else
    // Count consecutive denied debug cycles, saturating at the limit.
    if (bus.dbg_req && !dbg_gnt)
      starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);

    case (state)
      CORE_PRI: if (bus.dbg_req && !dbg_gnt && starve_nxt == STARVE_MAX) state_nxt = DBG_PRI;
      // Debug priority lasts only until debug is served (or gives up).
      DBG_PRI:  if (dbg_gnt || !bus.dbg_req) state_nxt = CORE_PRI;
      // The cycle in which dbg_lock falls is still a lock cycle.
      LOCK:     if (!bus.dbg_lock) state_nxt = CORE_PRI;
      default:  state_nxt = CORE_PRI;
    endcase
`endif

    // A lock only takes effect together with a granted debug access.
    if (dbg_gnt && bus.dbg_lock) state_nxt = LOCK;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= CORE_PRI;
      starve_cnt  <= '0;
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      core_rvalid <= core_gnt & ~bus.core_we;
      dbg_rvalid  <= dbg_gnt & ~bus.dbg_we;
    end
  end

  // Memory-side mux; all fields read zero when nobody is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = bus.core_we;
      mem_addr  = bus.core_addr;
      mem_wdata = bus.core_wdata;
    end else if (dbg_gnt) begin
      mem_we    = bus.dbg_we;
      mem_addr  = bus.dbg_addr;
      mem_wdata = bus.dbg_wdata;
    end
  end

  assign bus.mem_en      = core_gnt | dbg_gnt;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.core_gnt    = core_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = core_rvalid;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.dbg_rvalid  = dbg_rvalid;
  assign bus.dbg_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter, checked
// against a reference model built from the arbitration rules (who has priority, whether
// debug holds a lock, how long debug has waited) and a golden copy of memory contents.
module tb_dmem_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MAXS  = 4;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAXS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Single-port memory driven by the arbiter's mem_* outputs.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  // Reference model state
  bit            m_locked, m_dbg_turn;
  int            m_starve;
  bit            m_crv, m_drv, m_crd_known, m_drd_known;
  logic [DW-1:0] m_crdata, m_drdata;
  logic [DW-1:0] gold [DEPTH];
  bit            gold_vld [DEPTH];

  int n_chk = 0;
  int n_err = 0;

  bit            exp_cg, exp_dg;
  bit            obs_cg, obs_dg, obs_stall, obs_en, obs_crv, obs_drv;
  logic [DW-1:0] obs_crdata, obs_drdata;
  bit            got, in_lock, stall_seen, prev_dg, exp_b, c_pend, d_pend, lk;
  logic [DW-1:0] ldat [3];

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_dbg_turn = 1'b0;
    m_starve   = 0;
    m_crv      = 1'b0;
    m_drv      = 1'b0;
  endtask

  // Applies the rules to what happened at one clock edge.
  task automatic model_update(input bit cg, input bit dg);
    bit denied, nl;
    m_crv = cg && !bus.core_we;
    m_drv = dg && !bus.dbg_we;
    if (m_crv) begin m_crdata = gold[bus.core_addr]; m_crd_known = gold_vld[bus.core_addr]; end
    if (m_drv) begin m_drdata = gold[bus.dbg_addr];  m_drd_known = gold_vld[bus.dbg_addr];  end
    if (cg && bus.core_we) begin gold[bus.core_addr] = bus.core_wdata; gold_vld[bus.core_addr] = 1'b1; end
    if (dg && bus.dbg_we)  begin gold[bus.dbg_addr]  = bus.dbg_wdata;  gold_vld[bus.dbg_addr]  = 1'b1; end
    denied = bus.dbg_req && !dg;
`ifdef DMEM_ARB_RR_EN
    if (cg)      m_dbg_turn = 1'b1;
    else if (dg) m_dbg_turn = 1'b0;
`else
    m_starve = denied ? ((m_starve + 1 > MAXS) ? MAXS : m_starve + 1) : 0;
    if (m_dbg_turn) m_dbg_turn = 1'b0;
    else            m_dbg_turn = denied && (m_starve == MAXS);
`endif
    nl = bus.dbg_lock && (dg || m_locked);
    if (nl || m_locked) m_dbg_turn = 1'b0;
    m_locked = nl;
  endtask

  // One cycle: inputs are already applied after a negedge; check, then advance the model.
  task automatic step();
    bit cg, dg, cr, dr;
    #1;
    if (!n_rst) model_reset();
    cr = bus.core_req;
    dr = bus.dbg_req;
    if (!n_rst)          begin cg = 1'b0; dg = 1'b0;       end
    else if (m_locked)   begin cg = 1'b0; dg = dr;         end
    else if (m_dbg_turn) begin dg = dr;   cg = cr && !dr;  end
    else                 begin cg = cr;   dg = dr && !cr;  end
    obs_cg = bus.core_gnt;  obs_dg = bus.dbg_gnt;  obs_stall = bus.core_stall;
    obs_en = bus.mem_en;    obs_crv = bus.core_rvalid; obs_drv = bus.dbg_rvalid;
    obs_crdata = bus.core_rdata; obs_drdata = bus.dbg_rdata;
    chk("core_gnt", bus.core_gnt, cg);
    chk("dbg_gnt", bus.dbg_gnt, dg);
    chk("core_stall", bus.core_stall, cr && !cg);
    chk("mem_en", bus.mem_en, cg || dg);
    chk("mem_we", bus.mem_we, cg ? bus.core_we : (dg ? bus.dbg_we : 1'b0));
    chk("mem_addr", bus.mem_addr, cg ? bus.core_addr : (dg ? bus.dbg_addr : '0));
    chk("mem_wdata", bus.mem_wdata, cg ? bus.core_wdata : (dg ? bus.dbg_wdata : '0));
    chk("core_rvalid", bus.core_rvalid, m_crv);
    chk("dbg_rvalid", bus.dbg_rvalid, m_drv);
    if (m_crv && m_crd_known) chk("core_rdata", bus.core_rdata, m_crdata);
    if (m_drv && m_drd_known) chk("dbg_rdata", bus.dbg_rdata, m_drdata);
    exp_cg = cg;
    exp_dg = dg;
    @(posedge clk);
    if (!n_rst) model_reset();
    else        model_update(cg, dg);
    @(negedge clk);
  endtask

  task automatic set_core(input bit req, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit lock);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    bus.dbg_lock = lock;
  endtask

  initial begin
    ldat[0] = 32'h11; ldat[1] = 32'h22; ldat[2] = 32'h33;
    set_core(1'b1, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b0, '0, '0, 1'b0);
    model_reset();
    n_rst = 1'b0;
    @(negedge clk);

    // Reset held two cycles with both ports requesting.
    step();
    step();
    chk("rst_core_gnt", obs_cg, 1'b0);
    chk("rst_dbg_gnt", obs_dg, 1'b0);
    chk("rst_mem_en", obs_en, 1'b0);
    chk("rst_rvalid", obs_crv | obs_drv, 1'b0);
    n_rst = 1'b1;
    step();
    chk("rel_core_gnt", obs_cg, 1'b1);

    // Core-only write then read-back.
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    set_core(1'b1, 1'b1, '0, 32'd100);
    step();
    stall_seen = obs_stall;
    set_core(1'b1, 1'b0, '0, '0);
    step();
    stall_seen |= obs_stall;
    chk("core_rd_gnt", obs_cg, 1'b1);
    set_core(1'b0, 1'b0, '0, '0);
    step();
    chk("core_rd_rvalid", obs_crv, 1'b1);
    chk("core_rd_data", obs_crdata, 32'd100);
    chk("core_no_stall", stall_seen, 1'b0);

    // Continuous contention.
    set_core(1'b1, 1'b0, AW'(5), '0);
    set_dbg(1'b1, 1'b0, AW'(6), '0, 1'b0);
    prev_dg = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
`ifdef DMEM_ARB_RR_EN
      if (i > 0) chk("rr_alternate", obs_dg, !prev_dg);
      chk("rr_one_gnt", obs_cg, !obs_dg);
      prev_dg = obs_dg;
`else
      exp_b = ((i % 5) == 4);
      chk("contend_dbg_gnt", obs_dg, exp_b);
      chk("contend_core_gnt", obs_cg, !exp_b);
      chk("contend_stall", obs_stall, exp_b);
`endif
    end

    // Locked debug burst against a continuously requesting core.
    set_core(1'b1, 1'b1, AW'(32), 32'h7);
    in_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_dbg(1'b1, 1'b1, AW'(16 + k), ldat[k], 1'b1);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        step();
        if (in_lock || obs_dg) chk("lock_stall", obs_stall, 1'b1);
        if (obs_dg) begin got = 1'b1; in_lock = 1'b1; end
      end
      chk("lock_wait_gnt", got, 1'b1);
    end
    set_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    set_core(1'b1, 1'b0, AW'(17), '0);
    step();
    chk("lock_fall_core_gnt", obs_cg, 1'b0);
    chk("lock_fall_stall", obs_stall, 1'b1);
    step();
    chk("post_lock_core_gnt", obs_cg, 1'b1);
    set_core(1'b0, 1'b0, '0, '0);
    step();
    chk("lock_rd_rvalid", obs_crv, 1'b1);
    chk("lock_rd_data", obs_crdata, 32'h22);

    // Reset arriving between a granted debug read and its edge.
    set_dbg(1'b1, 1'b0, AW'(16), '0, 1'b0);
    #1;
    chk("midrd_dbg_gnt", bus.dbg_gnt, 1'b1);
    #1;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    set_core(1'b1, 1'b0, '0, '0);
    step();
    chk("midrd_no_rvalid", obs_drv, 1'b0);
    chk("midrd_core_pri", obs_cg, 1'b1);

    // Randomized traffic, occasional locks and resets.
    c_pend = 1'b0; d_pend = 1'b0; lk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!c_pend) begin
        if ($urandom_range(0, 3) != 0) begin
          set_core(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
          c_pend = 1'b1;
        end else bus.core_req = 1'b0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 3) == 0) lk = !lk;
        if ($urandom_range(0, 2) != 0) begin
          set_dbg(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, lk);
          d_pend = 1'b1;
        end else begin
          bus.dbg_req  = 1'b0;
          bus.dbg_lock = lk;
        end
      end
      n_rst = ($urandom_range(0, 199) != 0);
      step();
      if (exp_cg) c_pend = 1'b0;
      if (exp_dg) d_pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
